// File: rtl/ckp_pkg.sv
// Shared types and default constants for the crankshaft wheel generator.
package ckp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } ckp_state_e;

    localparam int MIN_PERIOD = 4;
    localparam int TOOTH_NUM  = 60;
    localparam int GAP_TEETH  = 2;

endpackage

// File: rtl/counter.sv
// Generic loadable up/down counter: srst beats sload beats ena; sel=1 counts down.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             sload,
    input  logic             srst,
    input  logic             sel,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (srst) begin
            q_d = '0;
        end else if (sload) begin
            q_d = data;
        end else if (ena) begin
            q_d = sel ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/d_flip_flop.sv
// Enabled register with asynchronous active-low clear.
module d_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else if (ena) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ckp_wheel_gen.sv
// 60-2 style crankshaft wheel generator: one tooth per latched period, missing
// teeth emitted as a single long inactive gap before tooth 0.
module ckp_wheel_gen #(
    parameter int PER_WIDTH  = 24,
    parameter int TOOTH_NUM  = ckp_pkg::TOOTH_NUM,
    parameter int GAP_TEETH  = ckp_pkg::GAP_TEETH,
    parameter int TCNT_WIDTH = 6,
    parameter bit CKP_INV    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PER_WIDTH-1:0]  period_in,
    output logic                  ckp,
    output logic [TCNT_WIDTH-1:0] tooth_num,
    output logic                  rev_strobe,
    output logic                  running
);

    import ckp_pkg::*;

    // Two extra bits so GAP_TEETH*P fits for GAP_TEETH up to 3.
    localparam int CW = PER_WIDTH + 2;
    localparam logic [TCNT_WIDTH-1:0] LAST_TOOTH = TCNT_WIDTH'(TOOTH_NUM - GAP_TEETH - 1);
    localparam logic [TCNT_WIDTH-1:0] GAP_POS    = TCNT_WIDTH'(TOOTH_NUM - GAP_TEETH);

    function automatic logic [CW-1:0] high_len_m1(input logic [PER_WIDTH-1:0] p);
        return CW'(p >> 1) - CW'(1);
    endfunction

    function automatic logic [CW-1:0] low_len_m1(input logic [PER_WIDTH-1:0] p);
        return CW'(p) - CW'(p >> 1) - CW'(1);
    endfunction

    function automatic logic [CW-1:0] gap_len_m1(input logic [PER_WIDTH-1:0] p);
        return CW'(GAP_TEETH) * CW'(p) - CW'(1);
    endfunction

    ckp_state_e            state_q;
    ckp_state_e            state_d;
    logic [TCNT_WIDTH-1:0] tooth_q;
    logic [TCNT_WIDTH-1:0] tooth_d;
    logic                  ckp_q;
    logic                  rev_q;
    logic                  rev_d;
    logic                  run_q;

    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_val;
    logic                  cnt_ld;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_zero;

    logic [PER_WIDTH-1:0]  per_q;
    logic                  per_ld;
    logic                  start_ok;

    assign start_ok = ena && (period_in >= PER_WIDTH'(MIN_PERIOD));
    assign cnt_zero = (cnt_q == '0);
    assign cnt_en   = (state_q != IDLE);

    counter #(
        .WIDTH (CW)
    ) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .ena   (cnt_en),
        .sload (cnt_ld),
        .srst  (cnt_clr),
        .sel   (1'b1),
        .data  (cnt_val),
        .q     (cnt_q)
    );

    d_flip_flop #(
        .WIDTH (PER_WIDTH)
    ) u_per_latch (
        .clk (clk),
        .rst (rst),
        .ena (per_ld),
        .d   (period_in),
        .q   (per_q)
    );

    // Every entry into HIGH is a tooth boundary: period_in is latched only there.
    always_comb begin
        state_d = state_q;
        tooth_d = tooth_q;
        rev_d   = 1'b0;
        cnt_ld  = 1'b0;
        cnt_clr = 1'b0;
        cnt_val = '0;
        per_ld  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start_ok) begin
                    state_d = HIGH;
                    tooth_d = '0;
                    rev_d   = 1'b1;
                    per_ld  = 1'b1;
                    cnt_clr = 1'b0;
                    cnt_ld  = 1'b1;
                    cnt_val = high_len_m1(period_in);
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    state_d = LOW;
                    cnt_ld  = 1'b1;
                    cnt_val = low_len_m1(per_q);
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    if (tooth_q == LAST_TOOTH) begin
                        state_d = GAP;
                        tooth_d = GAP_POS;
                        cnt_ld  = 1'b1;
                        cnt_val = gap_len_m1(per_q);
                    end else if (start_ok) begin
                        state_d = HIGH;
                        tooth_d = tooth_q + TCNT_WIDTH'(1);
                        per_ld  = 1'b1;
                        cnt_ld  = 1'b1;
                        cnt_val = high_len_m1(period_in);
                    end else begin
                        state_d = IDLE;
                        tooth_d = '0;
                        cnt_clr = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    if (start_ok) begin
                        state_d = HIGH;
                        tooth_d = '0;
                        rev_d   = 1'b1;
                        per_ld  = 1'b1;
                        cnt_ld  = 1'b1;
                        cnt_val = high_len_m1(period_in);
                    end else begin
                        state_d = IDLE;
                        tooth_d = '0;
                        cnt_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tooth_d = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tooth_q <= '0;
            ckp_q   <= CKP_INV;
            rev_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tooth_q <= tooth_d;
            ckp_q   <= (state_d == HIGH) ^ CKP_INV;
            rev_q   <= rev_d;
            run_q   <= (state_d != IDLE);
        end
    end

    assign ckp        = ckp_q;
    assign tooth_num  = tooth_q;
    assign rev_strobe = rev_q;
    assign running    = run_q;

endmodule

// File: tb/tb_ckp_wheel_gen.sv
// Bench for ckp_wheel_gen: per-cycle reference model, per-period table, corner sequences.
module tb_ckp_wheel_gen;

    localparam int PW = 24;
    localparam int TW = 6;
    localparam int TN = 60;
    localparam int GT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic [PW-1:0] period_in = '0;
    logic          ckp;
    logic [TW-1:0] tooth_num;
    logic          rev_strobe;
    logic          running;

    always #5 clk = ~clk;

    ckp_wheel_gen #(
        .PER_WIDTH  (PW),
        .TOOTH_NUM  (TN),
        .GAP_TEETH  (GT),
        .TCNT_WIDTH (TW),
        .CKP_INV    (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .period_in  (period_in),
        .ckp        (ckp),
        .tooth_num  (tooth_num),
        .rev_strobe (rev_strobe),
        .running    (running)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: the current tooth (or gap) is described by its start
    // edge, its length and its latched period; outputs follow from the offset.
    bit m_act = 1'b0;
    bit m_gap = 1'b0;
    int m_start = 0;
    int m_tooth = 0;
    int m_p = 0;
    int m_len = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic start_tooth(input int k);
        m_act   = 1'b1;
        m_gap   = 1'b0;
        m_tooth = k;
        m_p     = int'(period_in);
        m_start = cyc;
        m_len   = m_p;
    endtask

    task automatic model_edge();
        bit ok;
        ok = ena && (int'(period_in) >= 4);
        if (!m_act) begin
            if (ok) start_tooth(0);
        end else if (cyc - m_start == m_len) begin
            if (!m_gap && m_tooth == TN - GT - 1) begin
                m_gap   = 1'b1;
                m_tooth = TN - GT;
                m_start = cyc;
                m_len   = GT * m_p;
            end else if (ok) begin
                start_tooth(m_gap ? 0 : m_tooth + 1);
            end else begin
                m_act = 1'b0;
            end
        end
    endtask

    task automatic model_check();
        logic       e_ckp;
        logic       e_rev;
        logic       e_run;
        logic [TW-1:0] e_tooth;
        e_ckp   = m_act && !m_gap && ((cyc - m_start) < (m_p / 2));
        e_rev   = m_act && !m_gap && (m_tooth == 0) && (cyc == m_start);
        e_run   = m_act;
        e_tooth = m_act ? TW'(m_tooth) : '0;
        n_cmp++;
        if ({ckp, tooth_num, rev_strobe, running} !== {e_ckp, e_tooth, e_rev, e_run}) begin
            n_bad++;
            $display("FAIL model cyc=%0d: got ckp=%b tooth=%0d rev=%b run=%b, want ckp=%b tooth=%0d rev=%b run=%b",
                     cyc, ckp, tooth_num, rev_strobe, running, e_ckp, e_tooth, e_rev, e_run);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) model_edge();
        else     m_act = 1'b0;
        @(negedge clk);
        model_check();
    endtask

    task automatic reset_dut();
        ena   = 1'b0;
        rst   = 1'b0;
        m_act = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic measure_rev(input int p, output int hi, output int lo, output int gap,
                               output int rr, output int rev, output int rises, output int maxt);
        int  n_rev;
        int  t_rev1;
        int  last_rise;
        bit  prev;
        bit  rise;
        n_rev = 0; t_rev1 = 0; last_rise = 0; prev = 1'b0;
        hi = 0; lo = 0; gap = 0; rr = 0; rev = 0; rises = 0; maxt = 0;
        for (int k = 0; k < 70 * p + 100 && n_rev < 2; k++) begin
            tick();
            rise = ckp && !prev;
            prev = ckp;
            if (rev_strobe && n_rev == 1) begin
                rev = cyc - t_rev1;
                if (cyc - last_rise > rr) rr = cyc - last_rise;
                n_rev = 2;
            end else if (rev_strobe && n_rev == 0) begin
                n_rev = 1;
                t_rev1 = cyc;
                last_rise = cyc;
                rises = rise ? 1 : 0;
                if (ckp) hi = 1; else lo = 1;
            end else if (n_rev == 1) begin
                if (rise) begin
                    if (cyc - last_rise > rr) rr = cyc - last_rise;
                    last_rise = cyc;
                    rises++;
                end
                if (tooth_num == 0) begin
                    if (ckp) hi++; else lo++;
                end
                if (int'(tooth_num) == TN - GT) gap++;
                if (int'(tooth_num) > maxt) maxt = int'(tooth_num);
            end
        end
        chk("rev_window_seen", n_rev, 2);
    endtask

    typedef struct {
        int period;
        int hi;
        int lo;
        int gap;
        int rr;
        int rev;
        int rises;
        int maxt;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int hi, lo, gap, rr, rev, rises, maxt;
        int h5, l5, h6, l6, c5, lo10, nrun, nrise, pat;
        bit prev, seen;

        tbl[0] = '{100, 50, 50, 200, 300, 6000, 58, 58};
        tbl[1] = '{101, 50, 51, 202, 303, 6060, 58, 58};
        tbl[2] = '{4,   2,  2,  8,   12,  240,  58, 58};
        tbl[3] = '{7,   3,  4,  14,  21,  420,  58, 58};

        #1 rst = 1'b0;
        #1;
        chk("rst_ckp", ckp, 0);
        chk("rst_tooth", tooth_num, 0);
        chk("rst_rev", rev_strobe, 0);
        chk("rst_running", running, 0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            reset_dut();
            period_in = PW'(tbl[i].period);
            ena = 1'b1;
            measure_rev(tbl[i].period, hi, lo, gap, rr, rev, rises, maxt);
            chk($sformatf("p%0d_high", tbl[i].period), hi, tbl[i].hi);
            chk($sformatf("p%0d_low", tbl[i].period), lo, tbl[i].lo);
            chk($sformatf("p%0d_gap", tbl[i].period), gap, tbl[i].gap);
            chk($sformatf("p%0d_rise_to_rise", tbl[i].period), rr, tbl[i].rr);
            chk($sformatf("p%0d_rev_period", tbl[i].period), rev, tbl[i].rev);
            chk($sformatf("p%0d_rises", tbl[i].period), rises, tbl[i].rises);
            chk($sformatf("p%0d_max_tooth", tbl[i].period), maxt, tbl[i].maxt);
        end

        // Period change in the middle of tooth 5 only affects tooth 6.
        reset_dut();
        period_in = PW'(100);
        ena = 1'b1;
        h5 = 0; l5 = 0; h6 = 0; l6 = 0; c5 = 0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (tooth_num == 5) begin
                if (ckp) h5++; else l5++;
                c5++;
                if (c5 == 30) period_in = PW'(200);
            end else if (tooth_num == 6) begin
                if (ckp) h6++; else l6++;
            end else if (tooth_num == 7) begin
                break;
            end
        end
        chk("chg_t5_high", h5, 50);
        chk("chg_t5_low", l5, 50);
        chk("chg_t6_high", h6, 100);
        chk("chg_t6_low", l6, 100);

        // ena dropped during tooth 10 HIGH: tooth completes, then idle.
        reset_dut();
        period_in = PW'(100);
        ena = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (tooth_num == 10 && ckp) begin
                seen = 1'b1;
                break;
            end
        end
        chk("drop_reached_t10", seen, 1);
        ena = 1'b0;
        lo10 = 0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (!running) break;
            if (tooth_num == 10 && !ckp) lo10++;
        end
        chk("drop_t10_low", lo10, 50);
        chk("drop_running", running, 0);
        chk("drop_ckp", ckp, 0);
        chk("drop_tooth", tooth_num, 0);
        nrise = 0;
        prev = ckp;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (ckp && !prev) nrise++;
            prev = ckp;
        end
        chk("drop_no_edges", nrise, 0);

        // Period below minimum keeps the generator idle; 4 then starts it.
        reset_dut();
        period_in = PW'(3);
        ena = 1'b1;
        nrun = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (running) nrun++;
        end
        chk("p3_running_cycles", nrun, 0);
        period_in = PW'(4);
        tick();
        chk("p4_rev_first", rev_strobe, 1);
        chk("p4_tooth_first", tooth_num, 0);
        pat = ckp ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pat = (pat << 1) | (ckp ? 1 : 0);
        end
        chk("p4_ckp_pattern", pat, 'b11001);
        chk("p4_tooth_second", tooth_num, 1);

        // Asynchronous reset in the middle of the gap.
        reset_dut();
        period_in = PW'(10);
        ena = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (int'(tooth_num) == TN - GT) begin
                seen = 1'b1;
                break;
            end
        end
        chk("gap_reached", seen, 1);
        for (int k = 0; k < 5; k++) tick();
        #2 rst = 1'b0;
        #1;
        m_act = 1'b0;
        chk("gaprst_ckp", ckp, 0);
        chk("gaprst_tooth", tooth_num, 0);
        chk("gaprst_rev", rev_strobe, 0);
        chk("gaprst_running", running, 0);
        tick();
        rst = 1'b1;

        // Random ena/period traffic against the model.
        reset_dut();
        ena = 1'b1;
        period_in = PW'($urandom_range(4, 30));
        for (int k = 0; k < 8000; k++) begin
            tick();
            if ($urandom_range(0, 299) == 0) ena = ~ena;
            if ($urandom_range(0, 49) == 0) period_in = PW'($urandom_range(2, 30));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
